mips_mem_responder: RTL and testbench
=====================================

// Module: mips_mem_responder
// PURPOSE
//  Memory-side responder for the mips_32 pipeline. Holds the unified 32-bit word-addressed
//  instruction/data memory and serves two request ports: instruction fetch (IF, read-only)
//  and data (D, load/store). Both ports use valid/ready request and response handshakes.
//  Exactly one transaction is in flight at a time, with programmable access latency.
// PARAMETERS
//  DEPTH    1024  memory words; valid word addresses are 0..DEPTH-1
//  ADDR_W   32    request address width; addresses are word indices
//  LAT      2     cycles from request accept to rsp_valid; legal range 1..15
// PORTS
//  clk1          in   1       sole clock; all logic on posedge
//  rst_n         in   1       synchronous reset, active-low
//  if_req_valid  in   1       IF read request
//  if_req_ready  out  1       IF request accepted this cycle when valid&&ready
//  if_req_addr   in   ADDR_W  IF word address (pc)
//  if_rsp_valid  out  1       IF instruction word valid
//  if_rsp_data   out  32      instruction word
//  if_rsp_ready  in   1       IF consumer accepts response
//  d_req_valid   in   1       D request
//  d_req_ready   out  1       D request accepted this cycle when valid&&ready
//  d_req_we      in   1       1=store (SW), 0=load (LW)
//  d_req_addr    in   ADDR_W  D word address (aluout)
//  d_req_wdata   in   32      store data (B operand)
//  d_rsp_valid   out  1       D response valid; also issued for stores as write ack
//  d_rsp_rdata   out  32      load data; 0 for stores
//  d_rsp_err     out  1       address out of range
//  d_rsp_ready   in   1       D consumer accepts response
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): state=IDLE, rr_last=IF (D wins the first tie), counter=0.
//   All rsp_valid=0, rsp_data/rdata=0, err=0. Memory array is not cleared.
//  req_ready is combinational: high only in IDLE, and only on the granted port.
//   Grant rules: if only one port is valid, it is granted. If both are valid, the port
//   that is not rr_last wins. If neither is valid, the grant goes to D.
//  States:
//   IDLE  on accept: latch port, we, addr, and wdata; update rr_last; set cnt=LAT-1.
//         Go to RESP if LAT==1, otherwise go to BUSY.
//   BUSY  decrement cnt each cycle; leave when cnt==1. On exit, perform the access:
//         the read uses the latched addr, and a store writes mem[addr]<=wdata.
//         Register the response and go to RESP.
//   RESP  hold the port's rsp_valid and data stable until rsp_ready=1. Then clear
//         rsp_valid on the next edge and go to IDLE. No new accept happens in that same cycle.
//  Latency: accept at edge N gives rsp_valid high from edge N+LAT. For back-to-back
//   requests with rsp_ready held high, throughput is one transaction per LAT+1 cycles.
//  The memory access occurs exactly once, on the edge that enters RESP. A store is
//   therefore visible to any later accepted read.
//  Out-of-range (addr>=DEPTH):
//   D load returns rdata=0 with err=1.
//   D store is dropped with err=1.
//   IF returns 32'hFC00_0000 (the HLT opcode), so the pipeline halts cleanly.
//  Only the addressed port's rsp_valid is asserted; the other port's rsp_valid stays 0.
//  Reset mid-operation (in BUSY or RESP): the transaction is abandoned. A store not yet
//   committed is not written; one already in RESP stays written.
//  Request inputs are ignored outside IDLE. The requester holds valid, addr, and data
//   stable until accepted.
// STRUCTURE
//  mips_pkg (shared with mips_32):
//   opcode constants (ADD..BEQZ, HLT=6'b111111) and the HLT_WORD=32'hFC00_0000 constant
//   instruction-type codes (RR_ALU..HALTED)
//   responder state enum {IDLE, BUSY, RESP}
//  Sub-module mips_mem_arb: 2-way round-robin arbiter (valids, accept, rr_last) -> grant.
//   The FSM, counter, and memory array stay in this module.
// TESTING
//  1. Reset, then D store addr=5, wdata=32'hDEAD_BEEF, LAT=2.
//     -> d_rsp_valid at accept+2, err=0, rdata=0.
//     -> A following D load addr=5 returns 32'hDEAD_BEEF.
//  2. IF and D both valid in the first IDLE cycle after reset (IF addr=0, D load addr=5).
//     -> D granted first and IF second. A repeat tie grants IF first (alternating).
//  3. Hold d_rsp_ready=0 for 4 cycles after d_rsp_valid.
//     -> rsp_valid and rdata stay stable and both req_ready stay 0.
//     -> Releasing rsp_ready returns the block to IDLE one edge later.
//  4. IF addr=1024 -> if_rsp_data=32'hFC00_0000.
//     D store addr=2000 -> err=1, and a load at addr 2000 returns 0 with err=1.
//  5. D store addr=7 accepted with LAT=4; rst_n=0 for one edge during BUSY.
//     -> state IDLE, no rsp_valid, mem[7] unchanged (write a known value beforehand).
//  6. LAT=1 with streaming IF requests addr 0..7 and rsp_ready=1.
//     -> one response per 2 cycles with words matching the preloaded memory.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: opcodes, instruction-type codes and memory-responder types shared
// by the mips_32 pipeline and its memory responder.
package mips_pkg;

   // Opcodes
   localparam logic [5:0] OP_ADD   = 6'b000000;
   localparam logic [5:0] OP_SUB   = 6'b000001;
   localparam logic [5:0] OP_AND   = 6'b000010;
   localparam logic [5:0] OP_OR    = 6'b000011;
   localparam logic [5:0] OP_SLT   = 6'b000100;
   localparam logic [5:0] OP_MUL   = 6'b000101;
   localparam logic [5:0] OP_LW    = 6'b001000;
   localparam logic [5:0] OP_SW    = 6'b001001;
   localparam logic [5:0] OP_ADDI  = 6'b001010;
   localparam logic [5:0] OP_SUBI  = 6'b001011;
   localparam logic [5:0] OP_SLTI  = 6'b001100;
   localparam logic [5:0] OP_BNEQZ = 6'b001101;
   localparam logic [5:0] OP_BEQZ  = 6'b001110;
   localparam logic [5:0] OP_HLT   = 6'b111111;

   // A halt instruction word; returned for out-of-range fetches so the pipeline stops cleanly.
   localparam logic [31:0] HLT_WORD = {OP_HLT, 26'd0};

   typedef enum logic [2:0] {
      RR_ALU = 3'b000,
      RM_ALU = 3'b001,
      LOAD   = 3'b010,
      STORE  = 3'b011,
      BRANCH = 3'b100,
      HALTED = 3'b101
   } instr_type_t;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      BUSY = 2'b01,
      RESP = 2'b10
   } rsp_state_t;

   typedef enum logic {
      PORT_IF = 1'b0,
      PORT_D  = 1'b1
   } port_t;

endpackage

// File: rtl/mips_mem_arb.sv
// mips_mem_arb: two-way round-robin arbiter between the instruction-fetch and
// data ports. Owns the "last granted" pointer; D wins the first tie after reset.
module mips_mem_arb
   import mips_pkg::*;
(
   input  logic  clk1,
   input  logic  rst_n,
   input  logic  i_if_valid,
   input  logic  i_d_valid,
   input  logic  i_accept,
   output port_t o_grant
);

   port_t r_rr_last;
   port_t w_grant;

   // Grant: lone requester wins, a tie goes to the port not granted last, idle defaults to D.
   // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
   always_comb begin
      w_grant = PORT_D;
      if (i_if_valid && i_d_valid) begin
         w_grant = (r_rr_last == PORT_IF) ? PORT_D : PORT_IF;
      end else if (i_if_valid) begin
         w_grant = PORT_IF;
      end
   end

   // Remember which port was granted on each accepted request.
   // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk1) begin
      if (!rst_n) begin
         r_rr_last <= PORT_IF;
      end else if (i_accept) begin
         r_rr_last <= w_grant;
      end
   end

   assign o_grant = w_grant;

endmodule

// File: rtl/mips_mem_responder.sv
// mips_mem_responder: unified word-addressed memory serving an IF (read-only)
// port and a D (load/store) port, one transaction in flight at a time.
// The response is registered LAT-1 edges after accept, so the requester first
// samples rsp_valid high on edge accept+LAT.
module mips_mem_responder
   import mips_pkg::*;
#(
   parameter int DEPTH  = 1024,
   parameter int ADDR_W = 32,
   parameter int LAT    = 2      // legal range 1..15 (4-bit counter)
) (
   input  logic              clk1,
   input  logic              rst_n,
   input  logic              if_req_valid,
   output logic              if_req_ready,
   input  logic [ADDR_W-1:0] if_req_addr,
   output logic              if_rsp_valid,
   output logic [31:0]       if_rsp_data,
   input  logic              if_rsp_ready,
   input  logic              d_req_valid,
   output logic              d_req_ready,
   input  logic              d_req_we,
   input  logic [ADDR_W-1:0] d_req_addr,
   input  logic [31:0]       d_req_wdata,
   output logic              d_rsp_valid,
   output logic [31:0]       d_rsp_rdata,
   output logic              d_rsp_err,
   input  logic              d_rsp_ready
);

   localparam int IDX_W = $clog2(DEPTH);

   rsp_state_t        r_state, w_state_nxt;
   logic [3:0]        r_cnt;
   port_t             r_port;
   logic              r_we;
   logic [ADDR_W-1:0] r_addr;
   logic [31:0]       r_wdata;
   logic [31:0]       r_mem [DEPTH];

   logic              r_if_rsp_valid, r_d_rsp_valid, r_d_rsp_err;
   logic [31:0]       r_if_rsp_data, r_d_rsp_rdata;

   port_t             w_grant, w_acc_port;
   logic              w_accept, w_access, w_rsp_ready, w_in_range, w_acc_we;
   logic [ADDR_W-1:0] w_acc_addr;
   logic [31:0]       w_acc_wdata, w_rd_word;
   logic [IDX_W-1:0]  w_idx;

   mips_mem_arb u_arb (
      .clk1       (clk1),
      .rst_n      (rst_n),
      .i_if_valid (if_req_valid),
      .i_d_valid  (d_req_valid),
      .i_accept   (w_accept),
      .o_grant    (w_grant)
   );

   assign if_req_ready = (r_state == IDLE) && (w_grant == PORT_IF);
   assign d_req_ready  = (r_state == IDLE) && (w_grant == PORT_D);
   assign w_accept     = (r_state == IDLE) && ((w_grant == PORT_IF) ? if_req_valid : d_req_valid);
   assign w_rsp_ready  = (r_port == PORT_IF) ? if_rsp_ready : d_rsp_ready;

   // Access operands: live request when LAT==1 accesses straight from IDLE, latched otherwise.
   always_comb begin
      w_acc_port  = r_port;
      w_acc_we    = r_we;
      w_acc_addr  = r_addr;
      w_acc_wdata = r_wdata;
      if (r_state == IDLE) begin
         w_acc_port  = w_grant;
         w_acc_we    = (w_grant == PORT_D) && d_req_we;
         w_acc_addr  = (w_grant == PORT_IF) ? if_req_addr : d_req_addr;
         w_acc_wdata = d_req_wdata;
      end
   end

   assign w_in_range = (w_acc_addr < ADDR_W'(DEPTH));
   assign w_idx      = w_acc_addr[IDX_W-1:0];
   assign w_rd_word  = r_mem[w_idx];

   // Next state; w_access marks the single edge that performs the memory access and enters RESP.
   always_comb begin
      w_state_nxt = r_state;
      w_access    = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (w_accept) begin
               w_state_nxt = (LAT == 1) ? RESP : BUSY;
               w_access    = (LAT == 1);
            end
         end
         BUSY: begin
            if (r_cnt == 4'd1) begin
               w_state_nxt = RESP;
               w_access    = 1'b1;
            end
         end
         RESP: begin
            if (w_rsp_ready) begin
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // State, latency counter and latched request.
   always_ff @(posedge clk1) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_port  <= PORT_IF;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept) begin
            r_cnt   <= 4'(LAT - 1);
            r_port  <= w_grant;
            r_we    <= w_acc_we;
            r_addr  <= w_acc_addr;
            r_wdata <= w_acc_wdata;
         end else if (r_state == BUSY) begin
            r_cnt <= r_cnt - 4'd1;
         end
      end
   end

   // Store commit; a reset on the access edge abandons the store.
   // NOTE: the memory array has no reset so it maps onto RAM and keeps contents across reset.
   always_ff @(posedge clk1) begin
      if (rst_n && w_access && (w_acc_port == PORT_D) && w_acc_we && w_in_range) begin
         r_mem[w_idx] <= w_acc_wdata;
      end
   end

   // Response registers: loaded on the access edge, valid dropped after the handshake.
   always_ff @(posedge clk1) begin
      if (!rst_n) begin
         r_if_rsp_valid <= 1'b0;
         r_if_rsp_data  <= '0;
         r_d_rsp_valid  <= 1'b0;
         r_d_rsp_rdata  <= '0;
         r_d_rsp_err    <= 1'b0;
      end else if (w_access) begin
         if (w_acc_port == PORT_IF) begin
            r_if_rsp_valid <= 1'b1;
            r_if_rsp_data  <= w_in_range ? w_rd_word : HLT_WORD;
         end else begin
            r_d_rsp_valid <= 1'b1;
            r_d_rsp_err   <= !w_in_range;
            r_d_rsp_rdata <= (w_in_range && !w_acc_we) ? w_rd_word : 32'd0;
         end
      end else if ((r_state == RESP) && w_rsp_ready) begin
         r_if_rsp_valid <= 1'b0;
         r_d_rsp_valid  <= 1'b0;
      end
   end

   assign if_rsp_valid = r_if_rsp_valid;
   assign if_rsp_data  = r_if_rsp_data;
   assign d_rsp_valid  = r_d_rsp_valid;
   assign d_rsp_rdata  = r_d_rsp_rdata;
   assign d_rsp_err    = r_d_rsp_err;

endmodule

// File: tb/tb_mips_mem_responder.sv
// Bench for mips_mem_responder: three instances (LAT 2, 4, 1) driven by directed
// vectors, a transaction-level reference model checked every cycle, and literal
// expectations for the key scenarios.
module tb_mips_mem_responder;
   import mips_pkg::*;

   localparam int N     = 3;
   localparam int DEPTH = 1024;

   function automatic int lat_of(input int k);
      return (k == 0) ? 2 : ((k == 1) ? 4 : 1);
   endfunction

   logic        clk1 = 1'b0;
   logic        rst_n        [N];
   logic        if_req_valid [N];
   logic        if_req_ready [N];
   logic [31:0] if_req_addr  [N];
   logic        if_rsp_valid [N];
   logic [31:0] if_rsp_data  [N];
   logic        if_rsp_ready [N];
   logic        d_req_valid  [N];
   logic        d_req_ready  [N];
   logic        d_req_we     [N];
   logic [31:0] d_req_addr   [N];
   logic [31:0] d_req_wdata  [N];
   logic        d_rsp_valid  [N];
   logic [31:0] d_rsp_rdata  [N];
   logic        d_rsp_err    [N];
   logic        d_rsp_ready  [N];

   always #5 clk1 = ~clk1;

   for (genvar g = 0; g < N; g++) begin : g_dut
      mips_mem_responder #(.DEPTH(DEPTH), .ADDR_W(32), .LAT(lat_of(g))) u_dut (
         .clk1         (clk1),
         .rst_n        (rst_n[g]),
         .if_req_valid (if_req_valid[g]),
         .if_req_ready (if_req_ready[g]),
         .if_req_addr  (if_req_addr[g]),
         .if_rsp_valid (if_rsp_valid[g]),
         .if_rsp_data  (if_rsp_data[g]),
         .if_rsp_ready (if_rsp_ready[g]),
         .d_req_valid  (d_req_valid[g]),
         .d_req_ready  (d_req_ready[g]),
         .d_req_we     (d_req_we[g]),
         .d_req_addr   (d_req_addr[g]),
         .d_req_wdata  (d_req_wdata[g]),
         .d_rsp_valid  (d_rsp_valid[g]),
         .d_rsp_rdata  (d_rsp_rdata[g]),
         .d_rsp_err    (d_rsp_err[g]),
         .d_rsp_ready  (d_rsp_ready[g])
      );
   end

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, cyc);
      end
   endtask

   // ------------------------------------------------------------------
   // Reference model: one transaction record per instance, timed in edges.
   // Port encoding in the model: 0 = IF, 1 = D.
   // ------------------------------------------------------------------
   logic [31:0] mmem    [N][DEPTH];
   bit          mknown  [N][DEPTH];
   bit          m_init  [N];
   bit          m_busy  [N];
   bit          m_rsp_on[N];
   int          m_due   [N];
   bit          m_port  [N];
   bit          m_we    [N];
   logic [31:0] m_addr  [N];
   logic [31:0] m_wdata [N];
   bit          m_rr_last[N];
   logic [31:0] m_data  [N];
   bit          m_err   [N];
   bit          m_known [N];

   function automatic bit grant_of(input int k);
      if (if_req_valid[k] && d_req_valid[k]) return !m_rr_last[k];
      if (if_req_valid[k]) return 1'b0;
      return 1'b1;
   endfunction

   function automatic void commit(input int k);
      bit inr;
      int a;
      inr        = (m_addr[k] < 32'(DEPTH));
      a          = inr ? int'(m_addr[k]) : 0;
      m_data[k]  = 32'd0;
      m_err[k]   = 1'b0;
      m_known[k] = 1'b1;
      if (!m_port[k]) begin
         if (inr) begin
            m_data[k]  = mmem[k][a];
            m_known[k] = mknown[k][a];
         end else begin
            m_data[k] = HLT_WORD;
         end
      end else if (!inr) begin
         m_err[k] = 1'b1;
      end else if (m_we[k]) begin
         mmem[k][a]   = m_wdata[k];
         mknown[k][a] = 1'b1;
      end else begin
         m_data[k]  = mmem[k][a];
         m_known[k] = mknown[k][a];
      end
   endfunction

   function automatic void model_step(input int k);
      bit g;
      if (!rst_n[k]) begin
         m_init[k]    = 1'b1;
         m_busy[k]    = 1'b0;
         m_rsp_on[k]  = 1'b0;
         m_rr_last[k] = 1'b0;
         return;
      end
      if (!m_init[k]) return;
      if (m_rsp_on[k]) begin
         if (m_port[k] ? d_rsp_ready[k] : if_rsp_ready[k]) begin
            m_rsp_on[k] = 1'b0;
            m_busy[k]   = 1'b0;
         end
      end else if (m_busy[k]) begin
         if (cyc == m_due[k]) begin
            commit(k);
            m_rsp_on[k] = 1'b1;
         end
      end else begin
         g = grant_of(k);
         if (g ? d_req_valid[k] : if_req_valid[k]) begin
            m_busy[k]    = 1'b1;
            m_port[k]    = g;
            m_we[k]      = g && d_req_we[k];
            m_addr[k]    = g ? d_req_addr[k] : if_req_addr[k];
            m_wdata[k]   = d_req_wdata[k];
            m_rr_last[k] = g;
            // Response is registered LAT-1 edges after accept (immediately for LAT=1).
            m_due[k]     = cyc + lat_of(k) - 1;
            if (lat_of(k) == 1) begin
               commit(k);
               m_rsp_on[k] = 1'b1;
            end
         end
      end
   endfunction

   always @(posedge clk1) begin
      cyc++;
      for (int k = 0; k < N; k++) model_step(k);
   end

   // Every-cycle comparison of all outputs against the model.
   always @(negedge clk1) begin
      for (int k = 0; k < N; k++) begin
         bit g;
         if (m_init[k]) begin
            g = grant_of(k);
            check($sformatf("u%0d if_req_ready", k), 32'(if_req_ready[k]), 32'(!m_busy[k] && !g));
            check($sformatf("u%0d d_req_ready", k),  32'(d_req_ready[k]),  32'(!m_busy[k] && g));
            check($sformatf("u%0d if_rsp_valid", k), 32'(if_rsp_valid[k]), 32'(m_rsp_on[k] && !m_port[k]));
            check($sformatf("u%0d d_rsp_valid", k),  32'(d_rsp_valid[k]),  32'(m_rsp_on[k] && m_port[k]));
            if (m_rsp_on[k] && m_known[k]) begin
               if (!m_port[k]) begin
                  check($sformatf("u%0d if_rsp_data", k), if_rsp_data[k], m_data[k]);
               end else begin
                  check($sformatf("u%0d d_rsp_rdata", k), d_rsp_rdata[k], m_data[k]);
                  check($sformatf("u%0d d_rsp_err", k), 32'(d_rsp_err[k]), 32'(m_err[k]));
               end
            end
         end
      end
   end

   // ------------------------------------------------------------------
   // Stimulus helpers (inputs change 1 time unit after posedge)
   // ------------------------------------------------------------------
   task automatic wait_accept(input int k, input bit is_d, output int acc_edge);
      bit ok;
      ok = 1'b0;
      for (int t = 0; t < 40 && !ok; t++) begin
         @(negedge clk1);
         ok = is_d ? (d_req_ready[k] && d_req_valid[k]) : (if_req_ready[k] && if_req_valid[k]);
         @(posedge clk1);
         #1;
      end
      check($sformatf("u%0d accept seen", k), 32'(ok), 32'd1);
      acc_edge = cyc;
      if (is_d) d_req_valid[k] = 1'b0;
      else      if_req_valid[k] = 1'b0;
   endtask

   // Returns at the negedge where rsp_valid is first seen; rsp_edge is the edge sampling it.
   task automatic wait_rsp(input int k, input bit is_d, output int rsp_edge);
      bit ok;
      ok = 1'b0;
      rsp_edge = -1;
      for (int t = 0; t < 40 && !ok; t++) begin
         @(negedge clk1);
         ok = is_d ? d_rsp_valid[k] : if_rsp_valid[k];
         if (ok) rsp_edge = cyc + 1;
      end
      check($sformatf("u%0d response seen", k), 32'(ok), 32'd1);
   endtask

   task automatic d_xact(input int k, input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rdata, output bit err, output int lat);
      int acc_edge, rsp_edge;
      d_req_we[k]    = we;
      d_req_addr[k]  = addr;
      d_req_wdata[k] = wdata;
      d_rsp_ready[k] = 1'b1;
      d_req_valid[k] = 1'b1;
      wait_accept(k, 1'b1, acc_edge);
      wait_rsp(k, 1'b1, rsp_edge);
      rdata = d_rsp_rdata[k];
      err   = d_rsp_err[k];
      lat   = rsp_edge - acc_edge;
      @(posedge clk1);
      #1;
   endtask

   task automatic if_xact(input int k, input logic [31:0] addr, output logic [31:0] data, output int lat);
      int acc_edge, rsp_edge;
      if_req_addr[k]  = addr;
      if_rsp_ready[k] = 1'b1;
      if_req_valid[k] = 1'b1;
      wait_accept(k, 1'b0, acc_edge);
      wait_rsp(k, 1'b0, rsp_edge);
      data = if_rsp_data[k];
      lat  = rsp_edge - acc_edge;
      @(posedge clk1);
      #1;
   endtask

   task automatic step();
      @(posedge clk1);
      #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   // ------------------------------------------------------------------
   // Directed scenarios
   // ------------------------------------------------------------------
   initial begin
      logic [31:0] rdata;
      bit          err;
      int          lat, acc_edge, rsp_edge, nacc, nrsp, last_acc;
      logic [3:0]  grants;
      int          ngr;
      bit          acc;

      for (int k = 0; k < N; k++) begin
         rst_n[k]        = 1'b0;
         if_req_valid[k] = 1'b0;
         if_req_addr[k]  = '0;
         if_rsp_ready[k] = 1'b1;
         d_req_valid[k]  = 1'b0;
         d_req_we[k]     = 1'b0;
         d_req_addr[k]   = '0;
         d_req_wdata[k]  = '0;
         d_rsp_ready[k]  = 1'b1;
      end
      step();
      step();
      for (int k = 0; k < N; k++) rst_n[k] = 1'b1;

      // Reset state
      @(negedge clk1);
      for (int k = 0; k < N; k++) begin
         check($sformatf("u%0d reset if_rsp_valid", k), 32'(if_rsp_valid[k]), 32'd0);
         check($sformatf("u%0d reset d_rsp_valid", k),  32'(d_rsp_valid[k]),  32'd0);
         check($sformatf("u%0d reset if_rsp_data", k),  if_rsp_data[k], 32'd0);
         check($sformatf("u%0d reset d_rsp_rdata", k),  d_rsp_rdata[k], 32'd0);
         check($sformatf("u%0d reset d_rsp_err", k),    32'(d_rsp_err[k]), 32'd0);
         check($sformatf("u%0d reset d_req_ready", k),  32'(d_req_ready[k]), 32'd1);
         check($sformatf("u%0d reset if_req_ready", k), 32'(if_req_ready[k]), 32'd0);
      end
      step();

      // 1. Store then load at addr 5, LAT=2
      d_xact(0, 1'b1, 32'd5, 32'hDEAD_BEEF, rdata, err, lat);
      check("t1 store latency", 32'(lat), 32'd2);
      check("t1 store err", 32'(err), 32'd0);
      check("t1 store rdata", rdata, 32'd0);
      d_xact(0, 1'b0, 32'd5, 32'd0, rdata, err, lat);
      check("t1 load rdata", rdata, 32'hDEAD_BEEF);
      check("t1 load latency", 32'(lat), 32'd2);

      // 2. Tie after reset: D first, then alternating while both stay valid
      d_xact(0, 1'b1, 32'd0, 32'h1234_5678, rdata, err, lat);
      rst_n[0] = 1'b0;
      step();
      rst_n[0] = 1'b1;
      if_req_addr[0]  = 32'd0;
      d_req_we[0]     = 1'b0;
      d_req_addr[0]   = 32'd5;
      if_req_valid[0] = 1'b1;
      d_req_valid[0]  = 1'b1;
      grants = '0;
      ngr    = 0;
      for (int t = 0; t < 60 && ngr < 4; t++) begin
         @(negedge clk1);
         if (d_rsp_valid[0])  check("t2 d rdata", d_rsp_rdata[0], 32'hDEAD_BEEF);
         if (if_rsp_valid[0]) check("t2 if data", if_rsp_data[0], 32'h1234_5678);
         if (if_req_ready[0] && if_req_valid[0]) begin
            grants = {grants[2:0], 1'b0};
            ngr++;
         end else if (d_req_ready[0] && d_req_valid[0]) begin
            grants = {grants[2:0], 1'b1};
            ngr++;
         end
         step();
      end
      if_req_valid[0] = 1'b0;
      d_req_valid[0]  = 1'b0;
      check("t2 grant order (1=D)", 32'(grants), 32'(4'b1010));
      repeat (6) step();

      // 3. Response stall: held stable, no request accepted
      d_rsp_ready[0] = 1'b0;
      d_req_we[0]    = 1'b0;
      d_req_addr[0]  = 32'd5;
      d_req_valid[0] = 1'b1;
      wait_accept(0, 1'b1, acc_edge);
      wait_rsp(0, 1'b1, rsp_edge);
      for (int i = 0; i < 4; i++) begin
         if (i > 0) @(negedge clk1);
         check("t3 hold d_rsp_valid", 32'(d_rsp_valid[0]), 32'd1);
         check("t3 hold rdata", d_rsp_rdata[0], 32'hDEAD_BEEF);
         check("t3 hold if_req_ready", 32'(if_req_ready[0]), 32'd0);
         check("t3 hold d_req_ready", 32'(d_req_ready[0]), 32'd0);
         step();
      end
      d_rsp_ready[0] = 1'b1;
      @(negedge clk1);
      check("t3 valid before release edge", 32'(d_rsp_valid[0]), 32'd1);
      step();
      @(negedge clk1);
      check("t3 valid after release", 32'(d_rsp_valid[0]), 32'd0);
      check("t3 idle after release", 32'(d_req_ready[0]), 32'd1);
      step();

      // 4. Out-of-range accesses
      if_xact(0, 32'd1024, rdata, lat);
      check("t4 if oor data", rdata, 32'hFC00_0000);
      d_xact(0, 1'b1, 32'd2000, 32'h5555_AAAA, rdata, err, lat);
      check("t4 oor store err", 32'(err), 32'd1);
      d_xact(0, 1'b0, 32'd2000, 32'd0, rdata, err, lat);
      check("t4 oor load rdata", rdata, 32'd0);
      check("t4 oor load err", 32'(err), 32'd1);

      // 5. Reset during BUSY abandons the store (LAT=4)
      d_xact(1, 1'b1, 32'd7, 32'hA5A5_0007, rdata, err, lat);
      check("t5 latency", 32'(lat), 32'd4);
      d_req_we[1]    = 1'b1;
      d_req_addr[1]  = 32'd7;
      d_req_wdata[1] = 32'h0BAD_0BAD;
      d_req_valid[1] = 1'b1;
      wait_accept(1, 1'b1, acc_edge);
      rst_n[1] = 1'b0;
      step();
      rst_n[1] = 1'b1;
      @(negedge clk1);
      check("t5 idle after reset", 32'(d_req_ready[1]), 32'd1);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk1);
         check("t5 no d_rsp_valid", 32'(d_rsp_valid[1]), 32'd0);
      end
      step();
      d_xact(1, 1'b0, 32'd7, 32'd0, rdata, err, lat);
      check("t5 mem[7] unchanged", rdata, 32'hA5A5_0007);

      // 6. LAT=1 streaming fetch
      for (int i = 0; i < 8; i++) begin
         d_xact(2, 1'b1, 32'(i), 32'hC0DE_0000 + 32'(i), rdata, err, lat);
         if (i == 0) check("t6 store latency", 32'(lat), 32'd1);
      end
      if_rsp_ready[2] = 1'b1;
      if_req_addr[2]  = 32'd0;
      if_req_valid[2] = 1'b1;
      nacc = 0;
      nrsp = 0;
      last_acc = 0;
      for (int t = 0; t < 60 && nrsp < 8; t++) begin
         @(negedge clk1);
         if (if_rsp_valid[2]) begin
            check($sformatf("t6 word %0d", nrsp), if_rsp_data[2], 32'hC0DE_0000 + 32'(nrsp));
            nrsp++;
         end
         acc = if_req_ready[2] && if_req_valid[2];
         step();
         if (acc) begin
            if (nacc > 0) check("t6 accept spacing", 32'(cyc - last_acc), 32'd2);
            last_acc = cyc;
            nacc++;
            if (nacc == 8) if_req_valid[2] = 1'b0;
            else           if_req_addr[2]  = 32'(nacc);
         end
      end
      check("t6 responses", 32'(nrsp), 32'd8);

      repeat (4) step();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
